// File: rtl/tb_mem_model.sv
// Synchronous RAM model for the memory side of an AXI-to-memory bridge.
// Adds configurable read latency, byte-enable writes, LFSR grant stalls and sticky out-of-range reporting.
module tb_mem_model #(
  parameter int unsigned NumWords    = 256,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 11,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned StallEn     = 0,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffsW    = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(NumWords);

  logic [AddrWidth-OffsW-1:0] w_idx;
  logic [IdxW-1:0]            w_mem_idx;
  logic                       w_oor;
  logic                       w_stall;
  logic                       w_accept;
  logic                       w_fb;
  logic [DataWidth-1:0]       w_resp_dat;
  logic                       w_unused;

  logic [15:0]                r_lfsr;
  logic [ReadLatency-1:0]     r_pipe_vld;
  logic [DataWidth-1:0]       r_pipe_dat [ReadLatency];
  logic                       r_err;
  logic [DataWidth-1:0]       r_mem [NumWords];

  // The byte offset inside a word does not select anything.
  assign w_unused  = ^addr_i[OffsW-1:0];
  assign w_idx     = addr_i[AddrWidth-1:OffsW];
  assign w_mem_idx = w_idx[IdxW-1:0];

  if (AddrWidth - OffsW > IdxW) begin : g_oor
    assign w_oor = |w_idx[AddrWidth-OffsW-1:IdxW];
  end else begin : g_no_oor
    assign w_oor = 1'b0;
  end

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_stall  = (StallEn != 0) && (r_lfsr[1:0] == 2'b00);
  assign gnt_o    = req_i & ~w_stall;
  assign w_accept = req_i & gnt_o;

  assign w_resp_dat = (we_i || w_oor) ? '0 : r_mem[w_mem_idx];

  // NOTE: every clocked state element uses non-blocking assignments so that
  // all registers sample values from before the edge, independent of order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LfsrSeed;
    end else if (StallEn != 0) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < ReadLatency; i++) r_pipe_dat[i] <= '0;
      r_err <= 1'b0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      r_pipe_dat[0] <= w_resp_dat;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_dat[i] <= r_pipe_dat[i-1];
      end
      if (w_accept && w_oor) r_err <= 1'b1;
    end
  end

  // NOTE: the storage array deliberately has no reset; contents survive rst_ni
  // and a reset loop over the whole array would not map onto a RAM macro.
  always_ff @(posedge clk_i) begin
    if (w_accept && we_i && !w_oor) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (strb_i[i]) r_mem[w_mem_idx][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rvalid_o = r_pipe_vld[ReadLatency-1];
  assign rdata_o  = r_pipe_dat[ReadLatency-1];
  assign err_o    = r_err;

endmodule

// File: tb/tb_tb_mem_model.sv
// Randomised bench for tb_mem_model: three instances (L=1, L=3, L=1 with stalls)
// share one stimulus stream and are each checked against a cycle-level reference model.
module tb_tb_mem_model;

  localparam logic [15:0] Seed = 16'hACE1;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  strb_i;

  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic [63:0] rdata  [3];

  always #5 clk_i = ~clk_i;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    tb_mem_model #(
      .NumWords   (256),
      .DataWidth  (64),
      .AddrWidth  (12),
      .ReadLatency(k == 1 ? 3 : 1),
      .StallEn    (k == 2 ? 1 : 0),
      .LfsrSeed   (Seed)
    ) u_dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (req_i),
      .gnt_o   (gnt[k]),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .wdata_i (wdata_i),
      .strb_i  (strb_i),
      .rvalid_o(rvalid[k]),
      .rdata_o (rdata[k]),
      .err_o   (err[k])
    );
  end

  // Reference model state, one copy per instance.
  logic [63:0] mem_m  [3][256];
  bit          err_m  [3];
  logic [15:0] lfsr_m [3];
  bit          exp_v  [3][16];
  logic [63:0] exp_d  [3][16];
  bit          last_acc [3];

  int edge_cnt  = 0;
  int n_checks  = 0;
  int n_errors  = 0;
  int gnt_cnt   = 0;
  int stall_cnt = 0;
  int rv_cnt    = 0;

  function automatic int lat(input int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit sen(input int k);
    return k == 2;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int v, b;
    v = int'(s);
    b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (b << 15));
  endfunction

  function automatic logic [63:0] pre(input int w);
    return (64'h1111_1111_1111_1111 * 64'(w + 1)) ^ 64'hDEAD_BEEF_0000_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check grant, advance model, check registered outputs after posedge.
  task automatic cycle(input bit rst, input bit r, input bit w, input logic [11:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    bit          exp_g;
    int          slot, idx;
    logic [63:0] dat;
    @(negedge clk_i);
    rst_ni = rst; req_i = r; we_i = w; addr_i = a; wdata_i = d; strb_i = s;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        for (int j = 0; j < 16; j++) exp_v[k][j] = 0;
        err_m[k]  = 0;
        lfsr_m[k] = Seed;
        check($sformatf("rst_rvalid%0d", k), 64'(rvalid[k]), 64'd0);
        check($sformatf("rst_rdata%0d", k), rdata[k], 64'd0);
        check($sformatf("rst_err%0d", k), 64'(err[k]), 64'd0);
      end
      exp_g = r && !(sen(k) && lfsr_m[k][1:0] == 2'b00);
      check($sformatf("gnt%0d", k), 64'(gnt[k]), 64'(exp_g));
      last_acc[k] = exp_g && rst;
      if (k == 2 && rst && r) begin
        if (exp_g) gnt_cnt++;
        else stall_cnt++;
      end
      if (last_acc[k]) begin
        idx = int'(a[11:3]);
        if (idx >= 256) begin
          dat = '0;
          err_m[k] = 1;
        end else begin
          dat = w ? 64'd0 : mem_m[k][idx];
          if (w) for (int b = 0; b < 8; b++) if (s[b]) mem_m[k][idx][b*8 +: 8] = d[b*8 +: 8];
        end
        slot = (edge_cnt + lat(k) - 1) % 16;
        exp_v[k][slot] = 1;
        exp_d[k][slot] = dat;
      end
      if (rst && sen(k)) lfsr_m[k] = lfsr_next(lfsr_m[k]);
    end
    @(posedge clk_i);
    #1;
    slot = edge_cnt % 16;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rvalid%0d", k), 64'(rvalid[k]), 64'(exp_v[k][slot]));
      if (exp_v[k][slot]) check($sformatf("rdata%0d", k), rdata[k], exp_d[k][slot]);
      check($sformatf("err%0d", k), 64'(err[k]), 64'(err_m[k]));
      if (k == 2 && rvalid[k] === 1'b1) rv_cnt++;
      exp_v[k][slot] = 0;
    end
    edge_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 12'h0, 64'd0, 8'h00);
  endtask

  initial begin
    bit          rs, rq, wr;
    logic [11:0] a;
    rst_ni = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; strb_i = '0;
    for (int k = 0; k < 3; k++) begin
      err_m[k] = 0; lfsr_m[k] = Seed;
      for (int j = 0; j < 16; j++) exp_v[k][j] = 0;
    end

    // Power-on reset; grant during reset follows the seed (low bits 01 -> no stall).
    cycle(0, 1, 0, 12'h000, 64'd0, 8'h00);
    cycle(0, 0, 0, 12'h000, 64'd0, 8'h00);
    idle(2);

    // Preload words 0..15, repeating each until the stalling instance also accepts.
    for (int w = 0; w < 16; w++) begin
      for (int t = 0; t < 20; t++) begin
        cycle(1, 1, 1, 12'(w * 8), pre(w), 8'hFF);
        if (last_acc[2]) break;
      end
      check($sformatf("preload_acc%0d", w), 64'(last_acc[2]), 64'd1);
    end
    idle(4);

    // Streaming reads on the latency-3 instance: pulses 3 cycles after the first accept.
    for (int i = 0; i < 6; i++) begin
      cycle(1, i < 4, 0, 12'(i * 8), 64'd0, 8'h00);
      check($sformatf("s3_rvalid%0d", i), 64'(rvalid[1]), 64'(i >= 2));
      if (i >= 2) check($sformatf("s3_rdata%0d", i), rdata[1], pre(i - 2));
    end
    idle(3);

    // Round trip and byte enables on the latency-1 instance.
    cycle(1, 1, 1, 12'h010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    check("s1_wr_rvalid", 64'(rvalid[0]), 64'd1);
    check("s1_wr_rdata", rdata[0], 64'd0);
    cycle(1, 1, 0, 12'h010, 64'd0, 8'h00);
    check("s1_rd_rdata", rdata[0], 64'h0123_4567_89AB_CDEF);
    cycle(1, 1, 1, 12'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    cycle(1, 1, 0, 12'h010, 64'd0, 8'h00);
    check("s2_rd_rdata", rdata[0], 64'h0123_4567_FFFF_FFFF);

    // Out-of-range write then read; word 0 must not be aliased.
    cycle(1, 1, 1, 12'h800, 64'hCAFE_F00D_CAFE_F00D, 8'hFF);
    check("s4_err_set", 64'(err[0]), 64'd1);
    cycle(1, 1, 0, 12'h800, 64'd0, 8'h00);
    check("s4_oor_rdata", rdata[0], 64'd0);
    cycle(1, 1, 0, 12'h000, 64'd0, 8'h00);
    check("s4_word0", rdata[0], pre(0));
    idle(3);
    check("s4_err_sticky", 64'(err[0]), 64'd1);

    // Reset with two reads in flight on the latency-3 instance.
    cycle(1, 1, 0, 12'h010, 64'd0, 8'h00);
    cycle(1, 1, 0, 12'h018, 64'd0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 12'h000, 64'd0, 8'h00);
    idle(5);
    cycle(1, 1, 0, 12'h010, 64'd0, 8'h00);
    check("s6_rd_after_rst", rdata[0], 64'h0123_4567_FFFF_FFFF);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom % 150) != 0;
      rq = rs && (($urandom % 4) != 0);
      wr = $urandom % 2;
      if ($urandom % 8 == 0) a = 12'h800 | 12'($urandom % 2048);
      else a = {1'b0, 8'($urandom % 16), 3'($urandom % 8)};
      cycle(rs, rq, wr, a, {$urandom, $urandom}, 8'($urandom));
    end
    idle(4);

    // Stall statistics: 1000 cycles of held read requests.
    gnt_cnt = 0; stall_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 1000; i++)
      cycle(1, 1, 0, {1'b0, 8'($urandom % 16), 3'b000}, 64'd0, 8'h00);
    idle(3);
    check("stall_ratio_ok", 64'(stall_cnt >= 175 && stall_cnt <= 325), 64'd1);
    check("rvalid_eq_gnt", 64'(rv_cnt), 64'(gnt_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
